// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load-store unit: data memory, memory-mapped I/O registers, load extension
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_lsu_addr          effective byte address (ALU result)
//   i_st_data           store data (rs2)
//   i_lsu_wren          store request
//   i_st_funct3         store size: 000 sb, 001 sh, else sw
//   i_sl_sel            load type: 000 lb, 001 lh, 011 lbu, 100 lhu, else lw
//   i_io_sw             asynchronous switch inputs
//   o_ld_data           extended load data (combinational)
//   o_misaligned        current access misaligned for its size (combinational)
//   o_io_ledr/ledg      LED registers
//   o_io_hex_lo/hex_hi  7-segment digit registers
//   o_io_lcd            LCD register

module lsu #(
   parameter int DMEM_ADDR_W = 11
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_st_data,
   input  logic        i_lsu_wren,
   input  logic [2:0]  i_st_funct3,
   input  logic [2:0]  i_sl_sel,
   input  logic [31:0] i_io_sw,
   output logic [31:0] o_ld_data,
   output logic        o_misaligned,
   output logic [31:0] o_io_ledr,
   output logic [31:0] o_io_ledg,
   output logic [31:0] o_io_hex_lo,
   output logic [31:0] o_io_hex_hi,
   output logic [31:0] o_io_lcd
);

   localparam int WIDX_W     = DMEM_ADDR_W - 2;
   localparam int DMEM_WORDS = 1 << WIDX_W;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   logic [31:0] dmem [0:DMEM_WORDS-1];

   logic [31:0] ledr_q, ledg_q, hex_lo_q, hex_hi_q, lcd_q;
   logic [31:0] sw_s1_q, sw_s2_q;

   logic [19:0] page;
   logic        sel_dmem, sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_lcd, sel_sw;
   logic [1:0]  st_size, ld_size;
   logic        st_mis, ld_mis, wr_ok;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rd_word, rd_shift;
   logic [WIDX_W-1:0] widx;

   // ---------------- address decode ----------------
   assign page       = i_lsu_addr[31:12];
   assign sel_dmem   = ((i_lsu_addr >> DMEM_ADDR_W) == 32'd0);
   assign sel_ledr   = (page == 20'h10000);
   assign sel_ledg   = (page == 20'h10001);
   assign sel_hex_lo = (page == 20'h10002);
   assign sel_hex_hi = (page == 20'h10003);
   assign sel_lcd    = (page == 20'h10004);
   assign sel_sw     = (page == 20'h10010);
   assign widx       = i_lsu_addr[DMEM_ADDR_W-1:2];

   // ---------------- access size and alignment ----------------
   always_comb begin
      st_size = SZ_W;
      case (i_st_funct3)
         3'b000:  st_size = SZ_B;
         3'b001:  st_size = SZ_H;
         default: st_size = SZ_W;
      endcase
      ld_size = SZ_W;
      case (i_sl_sel)
         3'b000, 3'b011: ld_size = SZ_B;
         3'b001, 3'b100: ld_size = SZ_H;
         default:        ld_size = SZ_W;
      endcase
   end

   assign st_mis = ((st_size == SZ_H) && i_lsu_addr[0]) ||
                   ((st_size == SZ_W) && (i_lsu_addr[1:0] != 2'b00));
   assign ld_mis = ((ld_size == SZ_H) && i_lsu_addr[0]) ||
                   ((ld_size == SZ_W) && (i_lsu_addr[1:0] != 2'b00));

   // The access is a store when wren is high, otherwise a load.
   assign o_misaligned = i_lsu_wren ? st_mis : ld_mis;
   assign wr_ok        = i_lsu_wren && !st_mis;

   // ---------------- byte enables and lane replication ----------------
   always_comb begin
      be    = 4'b0000;
      wdata = i_st_data;
      case (st_size)
         SZ_B: begin
            be[i_lsu_addr[1:0]] = 1'b1;
            wdata = {4{i_st_data[7:0]}};
         end
         SZ_H: begin
            be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{i_st_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = i_st_data;
         end
      endcase
   end

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  lane_en);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (lane_en[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

   // ---------------- data memory (not reset) ----------------
   always_ff @(posedge i_clk) begin
      if (wr_ok && sel_dmem) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) dmem[widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // ---------------- I/O output registers ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ledr_q   <= 32'd0;
         ledg_q   <= 32'd0;
         hex_lo_q <= 32'd0;
         hex_hi_q <= 32'd0;
         lcd_q    <= 32'd0;
      end else if (wr_ok) begin
         if (sel_ledr)   ledr_q   <= merge_lanes(ledr_q,   wdata, be);
         if (sel_ledg)   ledg_q   <= merge_lanes(ledg_q,   wdata, be);
         if (sel_hex_lo) hex_lo_q <= merge_lanes(hex_lo_q, wdata, be);
         if (sel_hex_hi) hex_hi_q <= merge_lanes(hex_hi_q, wdata, be);
         if (sel_lcd)    lcd_q    <= merge_lanes(lcd_q,    wdata, be);
      end
   end

   // Two-flop synchronizer for the asynchronous switch inputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sw_s1_q <= 32'd0;
         sw_s2_q <= 32'd0;
      end else begin
         sw_s1_q <= i_io_sw;
         sw_s2_q <= sw_s1_q;
      end
   end

   assign o_io_ledr   = ledr_q;
   assign o_io_ledg   = ledg_q;
   assign o_io_hex_lo = hex_lo_q;
   assign o_io_hex_hi = hex_hi_q;
   assign o_io_lcd    = lcd_q;

   // ---------------- load path ----------------
   always_comb begin
      rd_word = 32'd0;
      if (sel_dmem)        rd_word = dmem[widx];
      else if (sel_ledr)   rd_word = ledr_q;
      else if (sel_ledg)   rd_word = ledg_q;
      else if (sel_hex_lo) rd_word = hex_lo_q;
      else if (sel_hex_hi) rd_word = hex_hi_q;
      else if (sel_lcd)    rd_word = lcd_q;
      else if (sel_sw)     rd_word = sw_s2_q;
   end

   // Move the addressed byte/half down to bit 0 before extension.
   assign rd_shift = rd_word >> {i_lsu_addr[1:0], 3'b000};

   always_comb begin
      o_ld_data = rd_word;
      if (ld_mis) begin
         o_ld_data = 32'd0;
      end else begin
         case (i_sl_sel)
            3'b000:  o_ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  o_ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b011:  o_ld_data = {24'd0, rd_shift[7:0]};
            3'b100:  o_ld_data = {16'd0, rd_shift[15:0]};
            default: o_ld_data = rd_word;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu against a byte-level reference model

module tb_lsu;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] i_lsu_addr;
   logic [31:0] i_st_data;
   logic        i_lsu_wren;
   logic [2:0]  i_st_funct3;
   logic [2:0]  i_sl_sel;
   logic [31:0] i_io_sw;
   logic [31:0] o_ld_data;
   logic        o_misaligned;
   logic [31:0] o_io_ledr, o_io_ledg, o_io_hex_lo, o_io_hex_hi, o_io_lcd;

   lsu #(.DMEM_ADDR_W(11)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_lsu_addr   (i_lsu_addr),
      .i_st_data    (i_st_data),
      .i_lsu_wren   (i_lsu_wren),
      .i_st_funct3  (i_st_funct3),
      .i_sl_sel     (i_sl_sel),
      .i_io_sw      (i_io_sw),
      .o_ld_data    (o_ld_data),
      .o_misaligned (o_misaligned),
      .o_io_ledr    (o_io_ledr),
      .o_io_ledg    (o_io_ledg),
      .o_io_hex_lo  (o_io_hex_lo),
      .o_io_hex_hi  (o_io_hex_hi),
      .o_io_lcd     (o_io_lcd)
   );

   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [7:0]  mem_b [0:2047];
   bit          mem_k [0:2047];
   logic [31:0] io_m  [0:4];
   logic [31:0] sw_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic int st_bytes(input logic [2:0] f3);
      if (f3 == 3'b000) return 1;
      if (f3 == 3'b001) return 2;
      return 4;
   endfunction

   function automatic int ld_bytes(input logic [2:0] sel);
      if (sel == 3'b000 || sel == 3'b011) return 1;
      if (sel == 3'b001 || sel == 3'b100) return 2;
      return 4;
   endfunction

   function automatic bit is_mis(input logic [31:0] a, input int n);
      return (a % n) != 0;
   endfunction

   function automatic int io_index(input logic [31:0] a);
      int p;
      p = a / 4096;
      if (p >= 32'h10000 && p <= 32'h10004) return p - 32'h10000;
      return -1;
   endfunction

   function automatic logic [31:0] sw_expect();
      if (sw_q.size() >= 2) return sw_q[sw_q.size()-2];
      return 32'd0;
   endfunction

   task automatic model_word(input logic [31:0] a, output logic [31:0] w, output bit kn);
      int base;
      w  = 32'd0;
      kn = 1'b1;
      if (a < 2048) begin
         base = a - (a % 4);
         for (int k = 0; k < 4; k++) begin
            w  = w | (32'(mem_b[base+k]) << (8*k));
            kn = kn & mem_k[base+k];
         end
      end else if (io_index(a) >= 0) begin
         w = io_m[io_index(a)];
      end else if (a / 4096 == 32'h10010) begin
         w = sw_expect();
      end
   endtask

   task automatic model_load(input logic [31:0] a, input logic [2:0] sel,
                             output logic [31:0] v, output bit kn);
      logic [31:0] w;
      logic [31:0] part;
      int n;
      n = ld_bytes(sel);
      v = 32'd0;
      kn = 1'b1;
      if (is_mis(a, n)) return;
      model_word(a, w, kn);
      part = w >> (8 * (a % 4));
      case (sel)
         3'b000:  v = (part[7]  ? 32'hFFFFFF00 : 32'd0) | (part & 32'hFF);
         3'b001:  v = (part[15] ? 32'hFFFF0000 : 32'd0) | (part & 32'hFFFF);
         3'b011:  v = part & 32'hFF;
         3'b100:  v = part & 32'hFFFF;
         default: v = w;
      endcase
   endtask

   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      int n;
      logic [31:0] ba;
      logic [7:0]  b;
      int idx;
      n = st_bytes(f3);
      if (is_mis(a, n)) return;
      for (int k = 0; k < n; k++) begin
         ba = a + k;
         b  = 8'((d >> (8*k)) & 32'hFF);
         if (ba < 2048) begin
            mem_b[ba] = b;
            mem_k[ba] = 1'b1;
         end else begin
            idx = io_index(ba);
            if (idx >= 0) io_m[idx][8*(ba%4) +: 8] = b;
         end
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      sw_q.push_back(i_io_sw);
      #1;
   endtask

   task automatic check_io();
      check("ledr",   o_io_ledr,   io_m[0]);
      check("ledg",   o_io_ledg,   io_m[1]);
      check("hex_lo", o_io_hex_lo, io_m[2]);
      check("hex_hi", o_io_hex_hi, io_m[3]);
      check("lcd",    o_io_lcd,    io_m[4]);
   endtask

   // One cycle: drive, check combinational outputs, clock, update model, check registers.
   task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic [2:0] f3, input logic [2:0] sel);
      logic [31:0] exp_ld;
      bit kn;
      bit exp_mis;
      i_lsu_addr  = a;
      i_st_data   = d;
      i_lsu_wren  = we;
      i_st_funct3 = f3;
      i_sl_sel    = sel;
      #2;
      model_load(a, sel, exp_ld, kn);
      exp_mis = we ? is_mis(a, st_bytes(f3)) : is_mis(a, ld_bytes(sel));
      check("misaligned", {31'd0, o_misaligned}, {31'd0, exp_mis});
      if (kn) check("ld_data", o_ld_data, exp_ld);
      tick();
      if (we) model_store(a, d, f3);
      i_lsu_wren = 1'b0;
      check_io();
   endtask

   task automatic peek(input string tag, input logic [31:0] a, input logic [2:0] sel,
                       input logic [31:0] exp);
      i_lsu_addr = a;
      i_sl_sel   = sel;
      i_lsu_wren = 1'b0;
      #2;
      check(tag, o_ld_data, exp);
      tick();
   endtask

   localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011, LHU = 3'b100;

   initial begin
      logic [31:0] a;
      for (int i = 0; i < 2048; i++) begin
         mem_b[i] = 8'd0;
         mem_k[i] = 1'b0;
      end
      for (int i = 0; i < 5; i++) io_m[i] = 32'd0;

      // reset held while a store to LEDR is requested
      i_rst_n     = 1'b0;
      i_lsu_addr  = 32'h1000_0000;
      i_st_data   = 32'hDEAD_BEEF;
      i_lsu_wren  = 1'b1;
      i_st_funct3 = SW;
      i_sl_sel    = LW;
      i_io_sw     = 32'd0;
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      check("rst_ledr", o_io_ledr, 32'd0);
      check_io();
      i_lsu_wren = 1'b0;
      i_rst_n    = 1'b1;

      do_op(32'h1000_0000, 32'hDEAD_BEEF, 1'b1, SW, LW);
      check("ledr_after_sw", o_io_ledr, 32'hDEAD_BEEF);

      // byte/half stores merged into one word
      do_op(32'h10, 32'h1122_3344, 1'b1, SW, LW);
      do_op(32'h11, 32'h0000_00AA, 1'b1, SB, LW);
      do_op(32'h12, 32'h0000_BEEF, 1'b1, SH, LW);
      peek("merge_lw", 32'h10, LW, 32'hBEEF_AA44);

      // load extension
      do_op(32'h20, 32'h80FF_7F80, 1'b1, SW, LW);
      peek("lb_20",  32'h20, LB,  32'hFFFF_FF80);
      peek("lbu_20", 32'h20, LBU, 32'h0000_0080);
      peek("lh_22",  32'h22, LH,  32'hFFFF_80FF);
      peek("lhu_22", 32'h22, LHU, 32'h0000_80FF);
      peek("lb_21",  32'h21, LB,  32'h0000_007F);

      // misaligned accesses
      do_op(32'h30, 32'h0102_0304, 1'b1, SW, LW);
      i_lsu_addr = 32'h31; i_st_funct3 = SW; i_lsu_wren = 1'b1; #2;
      check("mis_sw", {31'd0, o_misaligned}, 32'd1);
      tick();
      i_lsu_wren = 1'b0;
      peek("mis_sw_nowrite", 32'h30, LW, 32'h0102_0304);
      i_lsu_addr = 32'h33; i_sl_sel = LH; #2;
      check("mis_lh_flag", {31'd0, o_misaligned}, 32'd1);
      check("mis_lh_data", o_ld_data, 32'd0);
      tick();

      // switches through the synchronizer; SW page is read-only
      i_io_sw = 32'h5A5A_0001;
      peek("sw_0edge", 32'h1001_0000, LW, 32'd0);
      peek("sw_1edge", 32'h1001_0000, LW, 32'd0);
      peek("sw_2edge", 32'h1001_0000, LW, 32'h5A5A_0001);
      do_op(32'h1001_0000, 32'hFFFF_FFFF, 1'b1, SW, LW);
      peek("sw_ro", 32'h1001_0000, LW, 32'h5A5A_0001);

      // unmapped and DMEM boundary
      do_op(32'h0, 32'hCAFE_F00D, 1'b1, SW, LW);
      do_op(32'h800, 32'h1234_5678, 1'b1, SW, LW);
      peek("unmapped_800", 32'h800, LW, 32'd0);
      peek("word0_kept",   32'h0,   LW, 32'hCAFE_F00D);
      do_op(32'h7FC, 32'h1357_9BDF, 1'b1, SW, LW);
      peek("top_word", 32'h7FC, LW, 32'h1357_9BDF);

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: a = 32'($urandom_range(0, 2047));
            4:          a = 32'h800 + 32'($urandom_range(0, 15));
            5, 6:       a = {20'h10000 + 20'($urandom_range(0, 4)), 12'($urandom_range(0, 4095))};
            7:          a = {20'h10010, 12'($urandom_range(0, 4095))};
            8:          a = $urandom;
            default:    a = 32'h7F8 + 32'($urandom_range(0, 7));
         endcase
         if ($urandom_range(0, 7) == 0) i_io_sw = $urandom;
         do_op(a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
